// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write scheduler.
// Provides the default widths, register count, pending-counter limit and the
// arbitration port selector used by the scheduler and its arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned NREGS   = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = 3;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

endpackage : regfile_pkg

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter for the register-file write port.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   req_a_i/req_b_i : competing requests (nonzero destination only)
//   pref_o          : current preference, used by the ready logic
//   gnt_a_o/gnt_b_o : one-hot grants, combinational
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      req_a_i,
  input  logic      req_b_i,
  output port_sel_t pref_o,
  output logic      gnt_a_o,
  output logic      gnt_b_o
);

  port_sel_t pref_q, pref_d;

  // Grant logic; on a contested grant the preference moves to the loser.
  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    pref_d  = pref_q;
    if (req_a_i && req_b_i) begin
      if (pref_q == PORT_A) begin
        gnt_a_o = 1'b1;
        pref_d  = PORT_B;
      end else begin
        gnt_b_o = 1'b1;
        pref_d  = PORT_A;
      end
    end else if (req_a_i) begin
      gnt_a_o = 1'b1;
    end else if (req_b_i) begin
      gnt_b_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pref_q <= PORT_A;
    end else begin
      pref_q <= pref_d;
    end
  end

  assign pref_o = pref_q;

endmodule : rr_arbiter2

// File: rtl/regfile_write_scheduler.sv
// Shares the single register-file write port between the ALU writeback (A)
// and the load-return path (B), and keeps per-register pending-write counters
// so decode can stall on read-after-write hazards.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   issue_valid/rd/ready       : decode issue of a register-writing instruction
//   src1, src2, stall          : decode sources and RAW hazard stall
//   a_*/b_*                    : writeback requests (valid/ready handshake)
//   RW, BusW, enableWrite      : registered register-file write port
//   sb_error                   : sticky retire-against-zero-count flag
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned CNT_W  = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic              stall,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              enableWrite,
  output logic              sb_error
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_TOP  = (1 << CNT_W) - 1;

  logic              comp_a, comp_b;
  logic              gnt_a, gnt_b;
  port_sel_t         pref;
  logic              issue_fire;

  logic              en_q, en_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  pend_q [NUM_REGS];
  logic [CNT_W-1:0]  pend_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v, dec_v;

  // Writes to R0 never compete; they are acknowledged and dropped.
  assign comp_a = a_valid && (a_rd != '0);
  assign comp_b = b_valid && (b_rd != '0);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_a_i (comp_a && !reset),
    .req_b_i (comp_b && !reset),
    .pref_o  (pref),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  // Ready: a port loses only when the other competes and holds the preference.
  assign a_ready = !reset && ((a_rd == '0) || !comp_b || (pref == PORT_A));
  assign b_ready = !reset && ((b_rd == '0) || !comp_a || (pref == PORT_B));

  assign issue_ready = !reset &&
                       !((issue_rd != '0) && (pend_q[issue_rd] == CNT_W'(CNT_TOP)));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  // Stall holds through the enableWrite cycle because pend drops only at its end.
  assign stall = ((src1 != '0) && (pend_q[src1] != '0)) ||
                 ((src2 != '0) && (pend_q[src2] != '0));

  // One-hot increment/decrement strobes per register.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (issue_fire) inc_v[issue_rd] = 1'b1;
    if (en_q)       dec_v[rw_q]     = 1'b1;
    inc_v[0] = 1'b0;
    dec_v[0] = 1'b0;
  end

  // Saturating pending counters; concurrent inc/dec of one register cancel.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r == 0) begin
        pend_d[r] = '0;
      end else if (inc_v[r] && !dec_v[r]) begin
        if (pend_q[r] != CNT_W'(CNT_TOP)) pend_d[r] = pend_q[r] + CNT_W'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        if (pend_q[r] != '0) pend_d[r] = pend_q[r] - CNT_W'(1);
      end
    end
    err_d = err_q || (en_q && (pend_q[rw_q] == '0));
  end

  // Next write-port contents; address/data hold when nothing is granted.
  always_comb begin
    en_d   = gnt_a || gnt_b;
    rw_d   = rw_q;
    busw_d = busw_q;
    if (gnt_a) begin
      rw_d   = a_rd;
      busw_d = a_data;
    end else if (gnt_b) begin
      rw_d   = b_rd;
      busw_d = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
      err_q  <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      en_q   <= en_d;
      rw_q   <= rw_d;
      busw_q <= busw_d;
      err_q  <= err_d;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
    end
  end

  assign enableWrite = en_q;
  assign RW          = rw_q;
  assign BusW        = busw_q;
  assign sb_error    = err_q;

endmodule : regfile_write_scheduler
